// File: rtl/lsu_split_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsu_split_unit
// Function : Load/store unit with byte-lane alignment, load extension and
//            two-beat splitting of misaligned accesses over a req/ack memory.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_split_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1,
  parameter int TIMEOUT        = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_type,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 resp_valid,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_err,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN/8-1:0]    mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int c_NB   = XLEN / 8;
  localparam int c_OFFW = $clog2(c_NB);
  localparam int c_SHW  = $clog2(XLEN) + 1;
  localparam int c_CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;

  state_t                     r_state, w_state_next;
  logic                       r_we, r_split, r_err;
  logic [2:0]                 r_type;
  logic [ADDR_W-c_OFFW-1:0]   r_line;
  logic [c_OFFW-1:0]          r_off;
  logic [3:0]                 r_size;
  logic [XLEN-1:0]            r_wdata, r_rdata;
  logic [c_CW-1:0]            r_cnt;

  logic [3:0]                 w_size;
  logic                       w_legal, w_misal, w_acc_err, w_to, w_beat;
  logic [c_OFFW-1:0]          w_off;
  logic [c_SHW-1:0]           w_sh0, w_sh1, w_ext_sh;
  logic [ADDR_W-1:0]          w_base;
  logic [2*c_NB-1:0]          w_be_wide;
  logic [2*XLEN-1:0]          w_wd_wide;
  logic                       w_sext;
  logic [XLEN-1:0]            w_lj, w_zx, w_ext;
  logic signed [XLEN-1:0]     w_sx;

  // Request decode: access size in bytes and type legality for this XLEN
  always_comb begin
    w_size  = 4'd4;
    w_legal = 1'b1;
    case (req_type)
      3'b000:         w_size = 4'd4;
      3'b001, 3'b010: w_size = 4'd2;
      3'b011, 3'b100: w_size = 4'd1;
      3'b101: begin w_size = 4'd8; w_legal = (XLEN == 64); end
      3'b110: begin w_size = 4'd4; w_legal = (XLEN == 64); end
      default:        w_legal = 1'b0;
    endcase
  end

  assign w_off     = req_addr[c_OFFW-1:0];
  assign w_misal   = (5'(w_off) + 5'(w_size)) > 5'(c_NB);
  assign w_acc_err = !w_legal || (w_misal && (MISALIGN_SPLIT == 0));
  assign w_beat    = (r_state == BEAT0) || (r_state == BEAT1);
  assign w_to      = w_beat && (TIMEOUT != 0) && (r_cnt == c_CW'(TIMEOUT));

  assign w_sh0     = c_SHW'({r_off, 3'b000});
  assign w_sh1     = c_SHW'(XLEN) - w_sh0;
  assign w_base    = {r_line, {c_OFFW{1'b0}}};
  assign w_be_wide = (((2*c_NB)'(1) << r_size) - (2*c_NB)'(1)) << r_off;
  assign w_wd_wide = {{XLEN{1'b0}}, r_wdata} << w_sh0;

  // Extension by left-justifying the field, then shifting back down
  always_comb begin
    w_ext_sh = '0;
    w_sext   = 1'b0;
    case (r_type)
      3'b000: begin w_ext_sh = c_SHW'(XLEN - 32); w_sext = 1'b1; end
      3'b001: begin w_ext_sh = c_SHW'(XLEN - 16); w_sext = 1'b1; end
      3'b010:       w_ext_sh = c_SHW'(XLEN - 16);
      3'b011: begin w_ext_sh = c_SHW'(XLEN - 8);  w_sext = 1'b1; end
      3'b100:       w_ext_sh = c_SHW'(XLEN - 8);
      3'b110:       w_ext_sh = c_SHW'(XLEN - 32);
      default:      w_ext_sh = '0;
    endcase
  end

  assign w_lj  = r_rdata << w_ext_sh;
  assign w_sx  = $signed(w_lj) >>> w_ext_sh;
  assign w_zx  = w_lj >> w_ext_sh;
  assign w_ext = w_sext ? w_sx : w_zx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    stall        = 1'b1;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_be       = '0;
    mem_wdata    = '0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (req_valid) w_state_next = w_acc_err ? RESP : BEAT0;
      end
      BEAT0: begin
        mem_req   = !w_to;
        mem_we    = !w_to && r_we;
        mem_addr  = w_base;
        mem_be    = w_be_wide[c_NB-1:0];
        mem_wdata = w_wd_wide[XLEN-1:0];
        if (w_to)         w_state_next = RESP;
        else if (mem_ack) w_state_next = r_split ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_req   = !w_to;
        mem_we    = !w_to && r_we;
        mem_addr  = w_base + ADDR_W'(c_NB);
        mem_be    = w_be_wide[2*c_NB-1:c_NB];
        mem_wdata = w_wd_wide[2*XLEN-1:XLEN];
        if (w_to || mem_ack) w_state_next = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_err     = r_err;
        resp_rdata   = (r_err || r_we) ? '0 : w_ext;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_split <= 1'b0;
      r_err   <= 1'b0;
      r_type  <= '0;
      r_line  <= '0;
      r_off   <= '0;
      r_size  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_type  <= req_type;
        r_line  <= req_addr[ADDR_W-1:c_OFFW];
        r_off   <= w_off;
        r_size  <= w_size;
        r_wdata <= req_wdata;
        r_split <= w_misal;
        r_err   <= w_acc_err;
        r_rdata <= '0;
      end
      // Beat 0 fills the low result lanes, beat 1 lands above them
      if (r_state == BEAT0 && mem_req && mem_ack && !r_we)
        r_rdata <= mem_rdata >> w_sh0;
      if (r_state == BEAT1 && mem_req && mem_ack && !r_we)
        r_rdata <= r_rdata | (mem_rdata << w_sh1);
      if (w_to) r_err <= 1'b1;
      if (w_state_next != r_state) r_cnt <= '0;
      else if (mem_req && !mem_ack) r_cnt <= r_cnt + c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_split_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_split_unit
// Function : Directed vector bench for lsu_split_unit (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_split_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        n_req_valid, n_req_ready, n_resp_valid, n_resp_err, n_stall;
  logic [31:0] n_resp_rdata, n_mem_addr, n_mem_wdata;
  logic        n_mem_req, n_mem_we;
  logic        n_mem_ack = 1'b1;
  logic [3:0]  n_mem_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_split_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu_split_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0), .TIMEOUT(4)) dut_ns (
    .clk(clk), .reset(reset),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
    .stall(n_stall), .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr),
    .mem_be(n_mem_be), .mem_wdata(n_mem_wdata), .mem_ack(n_mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    chk($sformatf("v%0d_ready", i), req_ready, 1);
    req_valid = 1'b1; req_we = v.we; req_type = v.typ;
    req_addr = v.addr; req_wdata = v.wdata; mem_ack = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.beats == 0) begin
      chk($sformatf("v%0d_no_memreq", i), mem_req, 0);
    end else begin
      chk($sformatf("v%0d_b0_req", i), mem_req, 1);
      chk($sformatf("v%0d_b0_we", i), mem_we, v.we);
      chk($sformatf("v%0d_b0_addr", i), mem_addr, v.a0);
      chk($sformatf("v%0d_b0_be", i), mem_be, v.be0);
      chk($sformatf("v%0d_b0_wdata", i), mem_wdata, v.wd0);
      mem_rdata = v.rd0;
      if (v.beats == 2) begin
        @(negedge clk);
        chk($sformatf("v%0d_b1_req", i), mem_req, 1);
        chk($sformatf("v%0d_b1_addr", i), mem_addr, v.a1);
        chk($sformatf("v%0d_b1_be", i), mem_be, v.be1);
        chk($sformatf("v%0d_b1_wdata", i), mem_wdata, v.wd1);
        mem_rdata = v.rd1;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
    chk($sformatf("v%0d_resp_err", i), resp_err, v.err);
    chk($sformatf("v%0d_resp_rdata", i), resp_rdata, v.rdata);
    @(negedge clk);
    chk($sformatf("v%0d_resp_pulse", i), resp_valid, 0);
    chk($sformatf("v%0d_ready_again", i), req_ready, 1);
  endtask

  initial begin
    //            we  typ     addr          wdata         rd0           rd1          bt a0            be0   wd0           a1            be1   wd1           rdata         err
    vecs[0]  = '{1'b0, 3'b000, 32'h100,      32'h0,        32'hDEADBEEF, 32'h0,       1, 32'h100,      4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 3'b011, 32'h103,      32'h0,        32'h80000000, 32'h0,       1, 32'h100,      4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h103,      32'h0,        32'h80000000, 32'h0,       1, 32'h100,      4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, 3'b000, 32'h1002,     32'hAABBCCDD, 32'h12345678, 32'h9ABCDEF0, 2, 32'h1000,     4'hC, 32'hCCDD0000, 32'h1004,     4'h3, 32'h0000AABB, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 3'b001, 32'hFFFFFFFF, 32'h0,        32'h85000000, 32'h000000F2, 2, 32'hFFFFFFFC, 4'h8, 32'h0,        32'h0,        4'h1, 32'h0,        32'hFFFFF285, 1'b0};
    vecs[5]  = '{1'b0, 3'b010, 32'h102,      32'h0,        32'h9ABC1234, 32'h0,       1, 32'h100,      4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00009ABC, 1'b0};
    vecs[6]  = '{1'b1, 3'b001, 32'h101,      32'h12345678, 32'hFFFFFFFF, 32'h0,       1, 32'h100,      4'h6, 32'h34567800, 32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[7]  = '{1'b1, 3'b011, 32'h7,        32'h000000AB, 32'h0,        32'h0,       1, 32'h4,        4'h8, 32'hAB000000, 32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[8]  = '{1'b0, 3'b000, 32'h5,        32'h0,        32'h44332211, 32'h00000055, 2, 32'h4,        4'hE, 32'h0,        32'h8,        4'h1, 32'h0,        32'h55443322, 1'b0};
    vecs[9]  = '{1'b0, 3'b101, 32'h10,       32'h0,        32'h0,        32'h0,       0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b0, 3'b111, 32'h0,        32'h0,        32'h0,        32'h0,       0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 3'b011, 32'h101,      32'h0,        32'h00007F00, 32'h0,       1, 32'h100,      4'h2, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000007F, 1'b0};
    vecs[12] = '{1'b1, 3'b000, 32'h3,        32'h11223344, 32'h0,        32'h0,       2, 32'h0,        4'h8, 32'h44000000, 32'h4,        4'h7, 32'h00112233, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 3'b010, 32'h3,        32'h0,        32'h7F000000, 32'h000000FF, 2, 32'h0,        4'h8, 32'h0,        32'h4,        4'h1, 32'h0,        32'h0000FF7F, 1'b0};

    reset = 1'b0; req_valid = 1'b0; n_req_valid = 1'b0; req_we = 1'b0;
    req_type = 3'b000; req_addr = '0; req_wdata = '0; mem_ack = 1'b1; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Timeout: ack never arrives
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'b000; req_addr = 32'h200;
    mem_ack = 1'b0; mem_rdata = 32'hCAFEF00D;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("to_memreq_c%0d", c), mem_req, 1);
      chk($sformatf("to_noresp_c%0d", c), resp_valid, 0);
    end
    @(negedge clk);
    chk("to_memreq_dropped", mem_req, 0);
    chk("to_stall", stall, 1);
    chk("to_noresp_c5", resp_valid, 0);
    @(negedge clk);
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_resp_rdata", resp_rdata, 0);
    @(negedge clk);
    chk("to_ready_again", req_ready, 1);
    mem_ack = 1'b1;

    // Reset asserted while holding in BEAT1
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_type = 3'b000; req_addr = 32'h1002; req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rb_beat1_addr", mem_addr, 32'h1004);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rb_still_beat1", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("rb_mem_req", mem_req, 0);
    chk("rb_stall", stall, 0);
    chk("rb_ready", req_ready, 1);
    chk("rb_resp_valid", resp_valid, 0);
    chk("rb_mem_addr", mem_addr, 0);
    chk("rb_mem_be", mem_be, 0);
    chk("rb_mem_wdata", mem_wdata, 0);
    chk("rb_mem_we", mem_we, 0);
    @(negedge clk);
    chk("rb_no_resp", resp_valid, 0);
    reset = 1'b1; mem_ack = 1'b1;
    run_vec(100, vecs[0]);

    // Split disabled: misaligned word is rejected without touching memory
    @(negedge clk);
    n_req_valid = 1'b1; req_we = 1'b0; req_type = 3'b000; req_addr = 32'h2;
    @(negedge clk);
    n_req_valid = 1'b0;
    chk("ns_resp_valid", n_resp_valid, 1);
    chk("ns_resp_err", n_resp_err, 1);
    chk("ns_resp_rdata", n_resp_rdata, 0);
    chk("ns_mem_req_t1", n_mem_req, 0);
    @(negedge clk);
    chk("ns_resp_pulse", n_resp_valid, 0);
    chk("ns_mem_req_t2", n_mem_req, 0);
    chk("ns_ready", n_req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_split_unit.md
Name: lsu_split_unit

Overview:
Parametrised load/store unit sitting between the CPU datapath (ALU address, RD2 store data, DMType) and a variable-latency data memory with a req/ack handshake. It generates word-aligned addresses and byte enables, shifts store data into lane position, and sign- or zero-extends load data. Misaligned accesses are either split into two memory beats and merged, or rejected with an error. The `stall` output freezes the PC and pipeline while an access is in flight.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64; NB = XLEN/8 byte lanes.
ADDR_W, 32, byte-address width.
MISALIGN_SPLIT, 1, 1 = split misaligned access into two beats; 0 = error response, no memory access.
TIMEOUT, 255, maximum cycles waiting for mem_ack per beat; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  access request from core
req_ready  out  1  unit can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_type  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned, 101 dword (XLEN=64 only), 110 word unsigned (XLEN=64 only)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid: misaligned (split disabled), illegal type, or timeout
stall  out  1  high whenever state != IDLE
mem_req  out  1  memory beat request, held until acked
mem_we  out  1  beat is a write
mem_addr  out  ADDR_W  NB-aligned beat address
mem_be  out  NB  byte enables
mem_wdata  out  XLEN  lane-aligned write data
mem_ack  in  1  beat complete; sampled only while mem_req=1
mem_rdata  in  XLEN  read data, valid with mem_ack

Behaviour:
- Reset (async, reset=0): state=IDLE; req_ready=1; resp_valid, resp_err, stall, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, resp_rdata = 0; timeout counter = 0.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: on req_valid && req_ready, register we/type/addr/wdata. Compute size S (1/2/4/8 bytes) and off = addr mod NB. Illegal type -> RESP with err. Misaligned (off+S > NB) with MISALIGN_SPLIT=0 -> RESP with err, no mem_req. Otherwise -> BEAT0.
- BEAT0: mem_req=1, mem_addr = addr with low log2(NB) bits cleared; mem_be = ((1<<S)-1)<<off, truncated to NB bits; mem_wdata = wdata << (8*off). Outputs are stable until ack. On mem_ack (same-cycle ack permitted): go to BEAT1 if split, else RESP. Load bytes off..NB-1 are captured into low result lanes.
- BEAT1: mem_addr = BEAT0 address + NB, modulo 2^ADDR_W (wraps to 0); mem_be = ((1<<S)-1) >> (NB-off); mem_wdata = wdata >> (8*(NB-off)). On ack, capture the upper bytes and go to RESP.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata = merged bytes, sign-extended for types 000 (XLEN=64), 001 and 011, and zero-extended for 010, 100 and 110; the word type in XLEN=32 is passed through. Then return to IDLE; req_ready is high again in the following cycle.
- Latency, aligned access with zero-wait memory: accept at T, mem_req at T+1, resp_valid at T+2. A split access adds one cycle per beat plus any memory wait cycles.
- Timeout: the counter clears at each beat entry and increments per cycle with mem_req && !mem_ack. On reaching TIMEOUT: drop mem_req that cycle, go to RESP with resp_err=1 and rdata=0. A BEAT0 timeout skips BEAT1. Partial writes already acked are not rolled back.
- mem_ack outside BEAT0/BEAT1 is ignored.
- Reset asserted mid-transaction aborts immediately to IDLE with no response.

Test Plan:
- XLEN=32, lw addr 0x100, mem_rdata=0xDEADBEEF acked same cycle -> mem_addr=0x100, be=1111; resp_valid at T+2, rdata=0xDEADBEEF, err=0.
- lb addr 0x103, mem_rdata=0x80000000 -> be=1000; rdata=0xFFFFFF80. Same access as lbu -> rdata=0x00000080.
- sw addr 0x1002, wdata 0xAABBCCDD, split=1 -> beat0: addr 0x1000, be=1100, wdata=0xCCDD0000; beat1: addr 0x1004, be=0011, wdata=0x0000AABB; one resp_valid.
- lh addr 0xFFFFFFFF (ADDR_W=32), split=1 -> beat1 mem_addr wraps to 0x00000000; halfword merged from byte 3 and byte 0 and sign-extended.
- MISALIGN_SPLIT=0, lw addr 0x2 -> no mem_req ever; resp_valid with err=1 at T+1.
- TIMEOUT=4, mem_ack held 0 -> mem_req high 4 cycles then low; resp_err=1. Separately, reset pulsed during BEAT1 -> all outputs return to reset values with no resp_valid, and the next request is accepted normally.
